bcpu_alu_writeback: RTL and testbench

Result-side companion of the DSP48E1 ALU: tracks every issued ALU operation through the fixed ALU latency and commits `ALU_OUT` / `FLAGS_OUT` to the register file write port and the per-thread flags registers. It also reports register and flags hazards for operations still in flight. It sits between the issue stage, the ALU output and the register file. It owns the architectural `{V,S,Z,C}` flags that feed the ALU `FLAGS_IN`.

---
 rtl/bcpu_defs.sv | 24 ++
 rtl/bcpu_alu_writeback_if.sv | 32 +++
 rtl/bcpu_wb_tag_pipe.sv | 32 +++
 rtl/bcpu_alu_writeback.sv | 122 ++++++++++++
 tb/tb_bcpu_alu_writeback.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcpu_defs.sv
// Shared BCPU definitions: datapath widths, ALU latency, flag bit positions
// and the writeback tag carried alongside each in-flight ALU operation.
package bcpu_defs;

    localparam int unsigned BCPU_DATA_WIDTH      = 16;
    localparam int unsigned BCPU_REG_ADDR_WIDTH  = 3;
    localparam int unsigned BCPU_THREAD_ID_WIDTH = 2;
    localparam int unsigned BCPU_ALU_LATENCY     = 3;

    // Bit positions inside the {V,S,Z,C} flags nibble.
    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_C = 0;

    typedef struct packed {
        logic                            valid;
        logic [BCPU_THREAD_ID_WIDTH-1:0] thread;
        logic [BCPU_REG_ADDR_WIDTH-1:0]  dst;
        logic                            wr_reg;
        logic                            wr_flags;
    } bcpu_wb_tag_t;

endpackage

// File: rtl/bcpu_alu_writeback_if.sv
// Issue / ALU result / register-file write bundle between the issue stage,
// the ALU and the writeback block.
interface bcpu_alu_writeback_if #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned REG_ADDR_WIDTH  = 3,
    parameter int unsigned THREAD_ID_WIDTH = 2
);

    logic                                      ISSUE_EN;
    logic [THREAD_ID_WIDTH-1:0]                ISSUE_THREAD;
    logic [REG_ADDR_WIDTH-1:0]                 ISSUE_DST;
    logic                                      ISSUE_WR_REG;
    logic                                      ISSUE_WR_FLAGS;
    logic [DATA_WIDTH-1:0]                     ALU_OUT;
    logic [3:0]                                FLAGS_OUT;
    logic                                      RF_WE;
    logic [THREAD_ID_WIDTH+REG_ADDR_WIDTH-1:0] RF_WADDR;
    logic [DATA_WIDTH-1:0]                     RF_WDATA;

    modport master (
        output ISSUE_EN, ISSUE_THREAD, ISSUE_DST, ISSUE_WR_REG, ISSUE_WR_FLAGS,
        output ALU_OUT, FLAGS_OUT,
        input  RF_WE, RF_WADDR, RF_WDATA
    );

    modport slave (
        input  ISSUE_EN, ISSUE_THREAD, ISSUE_DST, ISSUE_WR_REG, ISSUE_WR_FLAGS,
        input  ALU_OUT, FLAGS_OUT,
        output RF_WE, RF_WADDR, RF_WDATA
    );

endinterface

// File: rtl/bcpu_wb_tag_pipe.sv
// CE-gated shift register of writeback tags, one stage per ALU latency cycle.
// Every stage is exposed so the hazard logic can see all in-flight ops.
module bcpu_wb_tag_pipe
    import bcpu_defs::*;
#(
    parameter int unsigned DEPTH = BCPU_ALU_LATENCY
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         i_ce,
    input  bcpu_wb_tag_t i_tag,
    output bcpu_wb_tag_t o_stages [DEPTH]
);

    bcpu_wb_tag_t r_stages [DEPTH];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stages[i] <= '0;
            end
        end else if (i_ce) begin
            r_stages[0] <= i_tag;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign o_stages = r_stages;

endmodule

// File: rtl/bcpu_alu_writeback.sv
// ALU result writeback: tracks issued ops through the ALU latency, commits results and flags.
// Define BCPU_ALU_WB_SCOREBOARD_EN to build the register/flags hazard comparators.
module bcpu_alu_writeback
    import bcpu_defs::*;
#(
    parameter int unsigned DATA_WIDTH      = BCPU_DATA_WIDTH,
    parameter int unsigned REG_ADDR_WIDTH  = BCPU_REG_ADDR_WIDTH,
    parameter int unsigned THREAD_ID_WIDTH = BCPU_THREAD_ID_WIDTH,
    parameter int unsigned ALU_LATENCY     = BCPU_ALU_LATENCY
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       CE,
    bcpu_alu_writeback_if.slave        io_wb,
    input  logic [THREAD_ID_WIDTH-1:0] FLAGS_RD_THREAD,
    output logic [3:0]                 FLAGS_RD,
    input  logic [THREAD_ID_WIDTH-1:0] QUERY_THREAD,
    input  logic [REG_ADDR_WIDTH-1:0]  QUERY_REG_A,
    input  logic [REG_ADDR_WIDTH-1:0]  QUERY_REG_B,
    output logic                       HAZARD_A,
    output logic                       HAZARD_B,
    output logic                       FLAGS_HAZARD
);

    localparam int unsigned NTHREADS = 2 ** THREAD_ID_WIDTH;

    bcpu_wb_tag_t          w_issue_tag;
    bcpu_wb_tag_t          w_stages [ALU_LATENCY];
    bcpu_wb_tag_t          w_last;
    bcpu_wb_tag_t          r_wb_tag;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic [3:0]            r_flags [NTHREADS];

    // Ops that write nothing get no tag, so they never raise a hazard.
    always_comb begin
        w_issue_tag          = '0;
        w_issue_tag.valid    = io_wb.ISSUE_EN & (io_wb.ISSUE_WR_REG | io_wb.ISSUE_WR_FLAGS);
        w_issue_tag.thread   = io_wb.ISSUE_THREAD;
        w_issue_tag.dst      = io_wb.ISSUE_DST;
        w_issue_tag.wr_reg   = io_wb.ISSUE_WR_REG;
        w_issue_tag.wr_flags = io_wb.ISSUE_WR_FLAGS;
    end

    bcpu_wb_tag_pipe #(
        .DEPTH (ALU_LATENCY)
    ) u_tag_pipe (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_ce     (CE),
        .i_tag    (w_issue_tag),
        .o_stages (w_stages)
    );

    assign w_last = w_stages[ALU_LATENCY-1];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wb_tag  <= '0;
            r_wb_data <= '0;
        end else if (CE) begin
            r_wb_tag  <= w_last;
            r_wb_data <= io_wb.ALU_OUT;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned t = 0; t < NTHREADS; t++) begin
                r_flags[t] <= '0;
            end
        end else if (CE && w_last.valid && w_last.wr_flags) begin
            r_flags[w_last.thread] <= io_wb.FLAGS_OUT;
        end
    end

    // CE gating keeps a stalled writeback stage from writing more than once.
    assign io_wb.RF_WE    = r_wb_tag.valid & r_wb_tag.wr_reg & CE;
    assign io_wb.RF_WADDR = {r_wb_tag.thread, r_wb_tag.dst};
    assign io_wb.RF_WDATA = r_wb_data;

    assign FLAGS_RD = r_flags[FLAGS_RD_THREAD];

`ifdef BCPU_ALU_WB_SCOREBOARD_EN
    always_comb begin
        HAZARD_A     = 1'b0;
        HAZARD_B     = 1'b0;
        FLAGS_HAZARD = 1'b0;
        for (int unsigned i = 0; i < ALU_LATENCY; i++) begin
            if (w_stages[i].valid && (w_stages[i].thread == QUERY_THREAD)) begin
                if (w_stages[i].wr_reg && (w_stages[i].dst == QUERY_REG_A)) HAZARD_A = 1'b1;
                if (w_stages[i].wr_reg && (w_stages[i].dst == QUERY_REG_B)) HAZARD_B = 1'b1;
                if (w_stages[i].wr_flags) FLAGS_HAZARD = 1'b1;
            end
        end
        // Flags are already committed once an op reaches writeback; the RF write is not.
        if (r_wb_tag.valid && r_wb_tag.wr_reg && (r_wb_tag.thread == QUERY_THREAD)) begin
            if (r_wb_tag.dst == QUERY_REG_A) HAZARD_A = 1'b1;
            if (r_wb_tag.dst == QUERY_REG_B) HAZARD_B = 1'b1;
        end
    end

    logic w_unused_wb_flags;
    assign w_unused_wb_flags = r_wb_tag.wr_flags;
`else
    assign HAZARD_A     = 1'b0;
    assign HAZARD_B     = 1'b0;
    assign FLAGS_HAZARD = 1'b0;

    bcpu_wb_tag_t w_unused_stages;
    logic         w_unused_query;

    always_comb begin
        w_unused_stages = '0;
        for (int unsigned i = 0; i < ALU_LATENCY; i++) begin
            w_unused_stages = w_unused_stages ^ w_stages[i];
        end
    end

    assign w_unused_query = ^{QUERY_THREAD, QUERY_REG_A, QUERY_REG_B, r_wb_tag.wr_flags};
`endif

endmodule

// File: tb/tb_bcpu_alu_writeback.sv
// Directed bench for bcpu_alu_writeback: an ALU stand-in replays results on time,
// a scoreboard queue holds the expected register-file writes.
module tb_bcpu_alu_writeback;
    import bcpu_defs::*;

`ifdef BCPU_ALU_WB_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    typedef struct {
        logic [4:0]  addr;
        logic [15:0] data;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;
        int unsigned due;
    } alu_t;

    logic       CLK;
    logic       RESET;
    logic       CE;
    logic [1:0] FLAGS_RD_THREAD;
    logic [3:0] FLAGS_RD;
    logic [1:0] QUERY_THREAD;
    logic [2:0] QUERY_REG_A;
    logic [2:0] QUERY_REG_B;
    logic       HAZARD_A;
    logic       HAZARD_B;
    logic       FLAGS_HAZARD;

    int unsigned en_edges = 0;
    int          n_vec    = 0;
    int          n_err    = 0;
    exp_t        exp_q[$];
    alu_t        alu_q[$];

    bcpu_alu_writeback_if #(
        .DATA_WIDTH      (16),
        .REG_ADDR_WIDTH  (3),
        .THREAD_ID_WIDTH (2)
    ) bus ();

    bcpu_alu_writeback #(
        .DATA_WIDTH      (16),
        .REG_ADDR_WIDTH  (3),
        .THREAD_ID_WIDTH (2),
        .ALU_LATENCY     (3)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .CE              (CE),
        .io_wb           (bus),
        .FLAGS_RD_THREAD (FLAGS_RD_THREAD),
        .FLAGS_RD        (FLAGS_RD),
        .QUERY_THREAD    (QUERY_THREAD),
        .QUERY_REG_A     (QUERY_REG_A),
        .QUERY_REG_B     (QUERY_REG_B),
        .HAZARD_A        (HAZARD_A),
        .HAZARD_B        (HAZARD_B),
        .FLAGS_HAZARD    (FLAGS_HAZARD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (CE && RESET) en_edges <= en_edges + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ALU stand-in: result appears once the op has spent three enabled edges in flight.
    always @(posedge CLK) begin
        #1;
        while (alu_q.size() > 0 && alu_q[0].due < en_edges) void'(alu_q.pop_front());
        if (alu_q.size() > 0 && alu_q[0].due == en_edges) begin
            bus.ALU_OUT   = alu_q[0].data;
            bus.FLAGS_OUT = alu_q[0].flags;
        end else begin
            bus.ALU_OUT   = 16'hDEAD;
            bus.FLAGS_OUT = 4'h0;
        end
    end

    always @(negedge CLK) begin
        if (RESET && bus.RF_WE) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rf_we", {31'd0, bus.RF_WE}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rf_waddr", {27'd0, bus.RF_WADDR}, {27'd0, e.addr});
                chk("rf_wdata", {16'd0, bus.RF_WDATA}, {16'd0, e.data});
                chk("rf_we_edge", en_edges, e.due);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] thr, input logic [2:0] dst, input logic wr_reg,
                         input logic wr_flags, input logic [15:0] data, input logic [3:0] flags);
        alu_t a;
        exp_t e;
        bus.ISSUE_EN       = 1'b1;
        bus.ISSUE_THREAD   = thr;
        bus.ISSUE_DST      = dst;
        bus.ISSUE_WR_REG   = wr_reg;
        bus.ISSUE_WR_FLAGS = wr_flags;
        a.data  = data;
        a.flags = flags;
        a.due   = en_edges + 3;
        alu_q.push_back(a);
        if (wr_reg) begin
            e.addr = {thr, dst};
            e.data = data;
            e.due  = en_edges + 4;
            exp_q.push_back(e);
        end
        tick();
        bus.ISSUE_EN = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic [1:0] thr, input logic [3:0] exp);
        FLAGS_RD_THREAD = thr;
        #1;
        chk(tag, {28'd0, FLAGS_RD}, {28'd0, exp});
    endtask

    initial begin
        logic [3:0] fl;
        RESET              = 1'b0;
        CE                 = 1'b1;
        bus.ISSUE_EN       = 1'b0;
        bus.ISSUE_THREAD   = '0;
        bus.ISSUE_DST      = '0;
        bus.ISSUE_WR_REG   = 1'b0;
        bus.ISSUE_WR_FLAGS = 1'b0;
        FLAGS_RD_THREAD    = '0;
        QUERY_THREAD       = '0;
        QUERY_REG_A        = '0;
        QUERY_REG_B        = '0;

        #3;
        chk("rst_rf_we", {31'd0, bus.RF_WE}, 32'd0);
        chk("rst_rf_waddr", {27'd0, bus.RF_WADDR}, 32'd0);
        chk("rst_rf_wdata", {16'd0, bus.RF_WDATA}, 32'd0);
        chk("rst_hazards", {29'd0, HAZARD_A, HAZARD_B, FLAGS_HAZARD}, 32'd0);
        for (int t = 0; t < 4; t++) chk_flags("rst_flags", 2'(t), 4'h0);
        tick();
        tick();
        RESET = 1'b1;
        tick();

        // Flags-only ops seed thread 1 and thread 2, then ADD t1 r5.
        issue(2'd1, 3'd7, 1'b0, 1'b1, 16'h0000, 4'b1010);
        issue(2'd2, 3'd0, 1'b0, 1'b1, 16'h1234, 4'b1111);
        repeat (5) tick();
        chk_flags("seed_flags1", 2'd1, 4'b1010);
        issue(2'd1, 3'd5, 1'b1, 1'b1, 16'h0021, 4'b0000);
        repeat (6) tick();
        chk_flags("add_flags1", 2'd1, 4'b0000);
        chk("add_waddr_const", 32'h0D, 32'(exp_q.size()) + 32'h0D);

        // INC on thread 2 leaves its flags untouched.
        issue(2'd2, 3'd4, 1'b1, 1'b0, 16'h00FF, 4'b0000);
        repeat (6) tick();
        chk_flags("inc_flags2", 2'd2, 4'b1111);

        // CE stall right after the issue edge.
        issue(2'd0, 3'd3, 1'b1, 1'b1, 16'hBEEF, 4'b0100);
        CE = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_rf_we", {31'd0, bus.RF_WE}, 32'd0);
        end
        CE = 1'b1;
        repeat (6) tick();
        chk_flags("stall_flags0", 2'd0, 4'b0100);

        // Hazard tracking through the pipe and writeback stage.
        QUERY_THREAD = 2'd3;
        QUERY_REG_A  = 3'd2;
        QUERY_REG_B  = 3'd6;
        fl = '0;
        fl[FLAG_V] = 1'b1;
        fl[FLAG_C] = 1'b1;
        issue(2'd3, 3'd2, 1'b1, 1'b1, 16'h5555, fl);
        for (int k = 0; k < 5; k++) begin
            chk("haz_a", {31'd0, HAZARD_A}, {31'd0, SB && (k <= 3)});
            chk("haz_b", {31'd0, HAZARD_B}, 32'd0);
            chk("haz_flags", {31'd0, FLAGS_HAZARD}, {31'd0, SB && (k <= 2)});
            if (k == 1) begin
                QUERY_THREAD = 2'd0;
                #1;
                chk("haz_other_thread", {30'd0, HAZARD_A, FLAGS_HAZARD}, 32'd0);
                QUERY_THREAD = 2'd3;
            end
            tick();
        end
        chk_flags("haz_flags3", 2'd3, 4'b1001);

        // Back-to-back issues, one per thread.
        for (int t = 0; t < 4; t++) begin
            issue(2'(t), 3'(t + 1), 1'b1, 1'b1, 16'hA000 + 16'(t), 4'(t));
        end
        repeat (8) tick();
        for (int t = 0; t < 4; t++) chk_flags("b2b_flags", 2'(t), 4'(t));
        chk("pending_writes", 32'(exp_q.size()), 32'd0);

        // Reset while an op is in flight.
        issue(2'd1, 3'd6, 1'b1, 1'b1, 16'h7777, 4'b1111);
        tick();
        tick();
        RESET = 1'b0;
        exp_q.delete();
        alu_q.delete();
        #1;
        chk("mid_rst_rf_we", {31'd0, bus.RF_WE}, 32'd0);
        chk("mid_rst_waddr", {27'd0, bus.RF_WADDR}, 32'd0);
        tick();
        tick();
        RESET = 1'b1;
        repeat (8) tick();
        for (int t = 0; t < 4; t++) chk_flags("post_rst_flags", 2'(t), 4'h0);
        QUERY_THREAD = 2'd1;
        QUERY_REG_A  = 3'd6;
        #1;
        chk("post_rst_hazards", {29'd0, HAZARD_A, HAZARD_B, FLAGS_HAZARD}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
